// File: rtl/uart_rx_data_sampler_if.sv
// Signal bundle between the receiver control path and the oversampling bit sampler.
// The master side drives the line and sampling controls; the slave side returns the voted bit.
interface uart_rx_data_sampler_if;
  logic [5:0] prescale;
  logic       enable;
  logic [4:0] edge_count;
  logic       rx_in;
  logic       rx_sync;
  logic       sampled_bit;
  logic       sample_valid;
  logic       sample_noise;

  modport master (
    output prescale, enable, edge_count, rx_in,
    input  rx_sync, sampled_bit, sample_valid, sample_noise
  );

  modport slave (
    input  prescale, enable, edge_count, rx_in,
    output rx_sync, sampled_bit, sample_valid, sample_noise
  );
endinterface

// File: rtl/uart_rx_data_sampler.sv
// UART receive bit sampler: synchronises rx_in, takes three samples around mid-bit
// and emits a majority-voted bit with a one-cycle valid strobe and a noise flag.
module uart_rx_data_sampler #(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input logic                  clk,
  input logic                  reset,
  uart_rx_data_sampler_if.slave bus
);

  typedef enum logic [1:0] {
    CNT_IDLE,
    CNT_S0,
    CNT_S1
  } cnt_t;

  cnt_t                   r_cnt;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s0;
  logic                   r_s1;
  logic                   r_bit;
  logic                   r_valid;
  logic                   r_noise;

  logic [4:0] w_mid;
  logic       w_legal;
  logic       w_rx;
  logic       w_maj;
  logic       w_noise;
  logic       w_at_m1;
  logic       w_at_m;
  logic       w_at_p1;

  // Unsupported ratios leave w_legal low so no sample point can ever match.
  always_comb begin
    w_mid   = 5'd0;
    w_legal = 1'b0;
    case (bus.prescale)
      6'd8:    begin w_mid = 5'd4;  w_legal = 1'b1; end
      6'd16:   begin w_mid = 5'd8;  w_legal = 1'b1; end
      6'd32:   begin w_mid = 5'd16; w_legal = 1'b1; end
      default: begin w_mid = 5'd0;  w_legal = 1'b0; end
    endcase
  end

  assign w_rx    = r_sync[SYNC_STAGES-1];
  assign w_maj   = (r_s0 & r_s1) | (r_s0 & w_rx) | (r_s1 & w_rx);
  assign w_noise = !((r_s0 == r_s1) && (r_s1 == w_rx));
  assign w_at_m1 = w_legal && (bus.edge_count == w_mid - 5'd1);
  assign w_at_m  = w_legal && (bus.edge_count == w_mid);
  assign w_at_p1 = w_legal && (bus.edge_count == w_mid + 5'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync  <= {SYNC_STAGES{IDLE_LEVEL}};
      r_s0    <= IDLE_LEVEL;
      r_s1    <= IDLE_LEVEL;
      r_bit   <= IDLE_LEVEL;
      r_valid <= 1'b0;
      r_noise <= 1'b0;
      r_cnt   <= CNT_IDLE;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.rx_in};
      r_valid <= 1'b0;
      r_noise <= 1'b0;
      if (!bus.enable) begin
        r_cnt <= CNT_IDLE;
      end else if (w_at_m1) begin
        // The first sample point always restarts the sequence, whatever came before.
        r_s0  <= w_rx;
        r_cnt <= CNT_S0;
      end else if (w_at_m) begin
        if (r_cnt == CNT_S0) begin
          r_s1  <= w_rx;
          r_cnt <= CNT_S1;
        end else begin
          r_cnt <= CNT_IDLE;
        end
      end else if (w_at_p1) begin
        r_cnt <= CNT_IDLE;
        if (r_cnt == CNT_S1) begin
          r_bit   <= w_maj;
          r_noise <= w_noise;
          r_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_sync      = w_rx;
  assign bus.sampled_bit  = r_bit;
  assign bus.sample_valid = r_valid;
  assign bus.sample_noise = r_noise;

endmodule
